ps2_scancode_decoder: RTL and testbench
=======================================

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, output buffer entries (power of two, 2..16; used only when PS2_DECODER_FIFO_EN is defined).
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: ps2_received_data  input  8  byte from the PS/2 receiver, valid when strobe is high.
REQ-005 SHALL have port: ps2_received_data_strb  input  1  one-cycle pulse; one strobe is one received byte.
REQ-006 SHALL have port: char_data  output  8  ASCII character for the Morse encoder.
REQ-007 SHALL have port: char_valid  output  1  char_data holds an undelivered character.
REQ-008 SHALL have port: char_ready  input  1  downstream accepts; transfer when char_valid && char_ready.
REQ-009 SHALL have port: overflow  output  1  one-cycle pulse when a decoded character is dropped for lack of space.

Function
REQ-010 SHALL run a prefix FSM with states IDLE, EXT (after 0xE0), BRK (after 0xF0), EXT_BRK (after 0xE0 0xF0); the FSM advances only on strobe cycles.
REQ-011 SHALL transition on 0xE0 from any state to EXT; on 0xF0 from IDLE or BRK to BRK, and from EXT or EXT_BRK to EXT_BRK; on any other byte to IDLE after processing.
REQ-012 SHALL, in IDLE on a make code, look up the byte: 0x1C..0x1A letter set -> 'A'..'Z' (0x41..0x5A); 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 -> '0'..'9'; 0x29 -> 0x20; 0x49 -> '.'; 0x41 -> ','; 0x4A -> '/' (shift clear) or '?' (shift set).
REQ-013 SHALL set the shift flag on make 0x12 or 0x59 in IDLE and clear it on the same codes in BRK; shift codes produce no character.
REQ-014 SHALL discard silently all unmapped make codes, all break codes, and all codes in EXT/EXT_BRK (e.g. 0xAA, 0xFA, arrows).
REQ-015 SHALL present a decoded character with char_valid high on the cycle after its strobe cycle (latency 1).
REQ-016 SHALL hold char_data stable while char_valid && !char_ready.
REQ-017 SHALL, when the buffer is full and char_ready is low on a push cycle, drop the new character, keep the buffered content, and pulse overflow for one cycle.
REQ-018 SHALL accept a push on a full buffer without overflow when a pop occurs in the same cycle.
REQ-019 SHALL deliver characters in arrival order.

Reset
REQ-020 SHALL, on rst_n low, immediately force state IDLE, shift flag 0, buffer empty, char_valid 0, char_data 0x00, overflow 0.
REQ-021 SHALL discard any partially received prefix sequence and any buffered characters when reset asserts mid-operation.
REQ-022 SHALL leave reset synchronously on the first clk edge after rst_n rises, with no output glitch.

Configuration
REQ-023 SHALL, with PS2_DECODER_FIFO_EN defined, buffer up to FIFO_DEPTH characters in a circular FIFO with wrap-around read/write pointers.
REQ-024 SHALL, without PS2_DECODER_FIFO_EN, use a single holding register (depth 1) with identical handshake, overflow and latency rules.

Structure
REQ-025 SHALL place in shared package ps2_pkg: FSM state encoding, scan-code constants (0xE0, 0xF0, 0x12, 0x59), and the scan-code-to-ASCII lookup function.
REQ-026 SHALL implement the buffer as sub-module ps2_char_fifo (push/pop/full/empty), instantiated with depth 1 when the macro is absent.

Verification
REQ-027 SHALL cover: strobe 0x1C -> char_data 0x41 with char_valid high on the next cycle.
REQ-028 SHALL cover: 0xF0, 0x1C -> no character; then 0x32 -> 0x42.
REQ-029 SHALL cover: 0x12, 0x4A -> 0x3F; then 0xF0, 0x12, 0x4A -> 0x2F.
REQ-030 SHALL cover: 0xE0, 0x75, 0xE0, 0xF0, 0x75, then 0x1C -> only 0x41 emitted.
REQ-031 SHALL cover, with the macro defined and FIFO_DEPTH=4: 5 letters with char_ready=0 -> 4 buffered and one overflow pulse; releasing ready drains 4 characters in order.
REQ-032 SHALL cover: rst_n low after 0xF0 with 2 buffered -> outputs zero at once; then 0x1C after release -> 0x41.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code decoder: prefix FSM state
// encoding, scan-code constants and the scan-code-to-ASCII lookup.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // Returns {hit, ascii}; hit is 0 for codes that have no character.
  function automatic logic [8:0] scancode_to_ascii(input logic [7:0] code,
                                                   input logic       shift);
    logic [8:0] r;
    r = 9'h000;
    case (code)
      8'h1C: r = {1'b1, 8'h41}; 8'h32: r = {1'b1, 8'h42};
      8'h21: r = {1'b1, 8'h43}; 8'h23: r = {1'b1, 8'h44};
      8'h24: r = {1'b1, 8'h45}; 8'h2B: r = {1'b1, 8'h46};
      8'h34: r = {1'b1, 8'h47}; 8'h33: r = {1'b1, 8'h48};
      8'h43: r = {1'b1, 8'h49}; 8'h3B: r = {1'b1, 8'h4A};
      8'h42: r = {1'b1, 8'h4B}; 8'h4B: r = {1'b1, 8'h4C};
      8'h3A: r = {1'b1, 8'h4D}; 8'h31: r = {1'b1, 8'h4E};
      8'h44: r = {1'b1, 8'h4F}; 8'h4D: r = {1'b1, 8'h50};
      8'h15: r = {1'b1, 8'h51}; 8'h2D: r = {1'b1, 8'h52};
      8'h1B: r = {1'b1, 8'h53}; 8'h2C: r = {1'b1, 8'h54};
      8'h3C: r = {1'b1, 8'h55}; 8'h2A: r = {1'b1, 8'h56};
      8'h1D: r = {1'b1, 8'h57}; 8'h22: r = {1'b1, 8'h58};
      8'h35: r = {1'b1, 8'h59}; 8'h1A: r = {1'b1, 8'h5A};
      8'h45: r = {1'b1, 8'h30}; 8'h16: r = {1'b1, 8'h31};
      8'h1E: r = {1'b1, 8'h32}; 8'h26: r = {1'b1, 8'h33};
      8'h25: r = {1'b1, 8'h34}; 8'h2E: r = {1'b1, 8'h35};
      8'h36: r = {1'b1, 8'h36}; 8'h3D: r = {1'b1, 8'h37};
      8'h3E: r = {1'b1, 8'h38}; 8'h46: r = {1'b1, 8'h39};
      8'h29: r = {1'b1, 8'h20}; 8'h49: r = {1'b1, 8'h2E};
      8'h41: r = {1'b1, 8'h2C};
      8'h4A: r = shift ? {1'b1, 8'h3F} : {1'b1, 8'h2F};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_char_fifo.sv
// Circular character buffer with wrap-around pointers. DEPTH may be 1,
// in which case it degenerates to a single holding register.
// A push is accepted when there is room or when a pop happens in the
// same cycle; pop is ignored while empty. pop_data reads 0 when empty.
module ps2_char_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? 8'h00 : mem_q[rd_q];

  // Next pointer, count and storage contents.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_pop) rd_d = ptr_next(rd_q);
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = ptr_next(wr_q);
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder feeding a valid/ready character stream.
// Optional macro PS2_DECODER_FIFO_EN: buffer FIFO_DEPTH characters;
// without it a single holding register is used.
// Handshake: char_data/char_valid are held until the cycle where
// char_valid && char_ready, at which point the character is consumed.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ps2_received_data,
  input  logic       ps2_received_data_strb,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       overflow
);

`ifdef PS2_DECODER_FIFO_EN
  localparam int BUF_DEPTH = FIFO_DEPTH;
`else
  // FIFO_DEPTH has no effect in this build; the buffer is one entry.
  localparam int BUF_DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif

  ps2_state_t state_q, state_d;
  logic       shift_q, shift_d;
  logic       overflow_q, overflow_d;
  logic       push;
  logic [7:0] push_char;
  logic [8:0] lookup;
  logic       pop, full, empty;

  assign lookup     = scancode_to_ascii(ps2_received_data, shift_q);
  assign char_valid = !empty;
  assign pop        = char_valid && char_ready;
  assign overflow   = overflow_q;

  // Prefix FSM, shift tracking and character generation on strobe cycles.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    push       = 1'b0;
    push_char  = 8'h00;
    if (ps2_received_data_strb) begin
      if (ps2_received_data == SC_EXT) begin
        state_d = ST_EXT;
      end else if (ps2_received_data == SC_BRK) begin
        state_d = (state_q == ST_IDLE || state_q == ST_BRK) ? ST_BRK : ST_EXT_BRK;
      end else begin
        state_d = ST_IDLE;
        if (ps2_received_data == SC_LSHIFT || ps2_received_data == SC_RSHIFT) begin
          if (state_q == ST_IDLE) shift_d = 1'b1;
          else if (state_q == ST_BRK) shift_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
          push      = lookup[8];
          push_char = lookup[7:0];
        end
      end
    end
    overflow_d = push && full && !pop;
  end

  // Decoder state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
    end
  end

  ps2_char_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_char),
    .pop       (pop),
    .pop_data  (char_data),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder (works with or without
// PS2_DECODER_FIFO_EN; buffer depth follows the macro).
module tb_ps2_scancode_decoder;

`ifdef PS2_DECODER_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ps2_received_data;
  logic       ps2_received_data_strb;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;
  int ovf_cnt  = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] code;
    logic       exp_valid;
    logic [7:0] exp_char;
  } vec_t;

  vec_t vecs[$];

  ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .ps2_received_data      (ps2_received_data),
    .ps2_received_data_strb (ps2_received_data_strb),
    .char_data              (char_data),
    .char_valid             (char_valid),
    .char_ready             (char_ready),
    .overflow               (overflow)
  );

  // Clock
  always #5 clk = ~clk;

  // Overflow pulse monitor
  always @(negedge clk) if (overflow === 1'b1) ovf_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; pulses strobe for one cycle, returns at the next negedge.
  task automatic send_byte(input logic [7:0] b);
    ps2_received_data      = b;
    ps2_received_data_strb = 1'b1;
    @(negedge clk);
    ps2_received_data_strb = 1'b0;
    ps2_received_data      = 8'h00;
  endtask

  function automatic vec_t mk(input logic [7:0] c, input logic v, input logic [7:0] ch);
    vec_t r;
    r.code = c; r.exp_valid = v; r.exp_char = ch;
    return r;
  endfunction

  initial begin
    logic [7:0] codes[6];
    logic [7:0] chars[6];
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    chars = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};

    // Vector table: each byte sent with char_ready high.
    vecs.push_back(mk(8'h1C, 1, 8'h41));
    vecs.push_back(mk(8'hF0, 0, 8'h00));
    vecs.push_back(mk(8'h1C, 0, 8'h00));
    vecs.push_back(mk(8'h32, 1, 8'h42));
    vecs.push_back(mk(8'h12, 0, 8'h00));
    vecs.push_back(mk(8'h4A, 1, 8'h3F));
    vecs.push_back(mk(8'hF0, 0, 8'h00));
    vecs.push_back(mk(8'h12, 0, 8'h00));
    vecs.push_back(mk(8'h4A, 1, 8'h2F));
    vecs.push_back(mk(8'hE0, 0, 8'h00));
    vecs.push_back(mk(8'h75, 0, 8'h00));
    vecs.push_back(mk(8'hE0, 0, 8'h00));
    vecs.push_back(mk(8'hF0, 0, 8'h00));
    vecs.push_back(mk(8'h75, 0, 8'h00));
    vecs.push_back(mk(8'h1C, 1, 8'h41));
    vecs.push_back(mk(8'h45, 1, 8'h30));
    vecs.push_back(mk(8'h46, 1, 8'h39));
    vecs.push_back(mk(8'h29, 1, 8'h20));
    vecs.push_back(mk(8'h49, 1, 8'h2E));
    vecs.push_back(mk(8'h41, 1, 8'h2C));
    vecs.push_back(mk(8'h1A, 1, 8'h5A));
    vecs.push_back(mk(8'hAA, 0, 8'h00));
    vecs.push_back(mk(8'hFA, 0, 8'h00));
    vecs.push_back(mk(8'h59, 0, 8'h00));
    vecs.push_back(mk(8'h2D, 1, 8'h52));
    vecs.push_back(mk(8'h4A, 1, 8'h3F));
    vecs.push_back(mk(8'hF0, 0, 8'h00));
    vecs.push_back(mk(8'h59, 0, 8'h00));
    vecs.push_back(mk(8'h4A, 1, 8'h2F));
    vecs.push_back(mk(8'hE0, 0, 8'h00));
    vecs.push_back(mk(8'h1C, 0, 8'h00));
    vecs.push_back(mk(8'h16, 1, 8'h31));

    // Reset
    rst_n = 1'b0; ps2_received_data = 8'h00; ps2_received_data_strb = 1'b0; char_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_valid", 32'(char_valid), 32'h0);
    check("reset_data", 32'(char_data), 32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven decode checks
    char_ready = 1'b1;
    foreach (vecs[i]) begin
      send_byte(vecs[i].code);
      check($sformatf("vec%0d_valid(code %02h)", i, vecs[i].code), 32'(char_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_data(code %02h)", i, vecs[i].code), 32'(char_data), 32'(vecs[i].exp_char));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'h0);
      @(negedge clk);
    end

    // Fill buffer with ready low, one extra letter overflows
    char_ready = 1'b0;
    ovf_cnt = 0;
    exp_q.delete();
    for (int i = 0; i <= DEPTH; i++) begin
      send_byte(codes[i]);
      if (i < DEPTH) exp_q.push_back(chars[i]);
      @(negedge clk);
    end
    check("fill_overflow_pulses", 32'(ovf_cnt), 32'd1);
    check("fill_valid", 32'(char_valid), 32'h1);
    check("fill_head_held", 32'(char_data), 32'(exp_q[0]));

    // Push on full with simultaneous pop: no overflow
    char_ready = 1'b1;
    send_byte(chars[5] == 8'h46 ? codes[5] : 8'h00);
    char_ready = 1'b0;
    exp_q.push_back(chars[5]);
    void'(exp_q.pop_front());
    check("push_pop_full_no_ovf", 32'(ovf_cnt), 32'd1);
    check("push_pop_full_overflow", 32'(overflow), 32'h0);

    // Drain in order
    char_ready = 1'b1;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check("drain_valid", 32'(char_valid), 32'h1);
      check("drain_data", 32'(char_data), 32'(e));
      @(negedge clk);
    end
    check("drain_empty", 32'(char_valid), 32'h0);

    // Reset mid-sequence with buffered characters and a pending break prefix
    char_ready = 1'b0;
    send_byte(8'h1C); @(negedge clk);
    send_byte(8'h32); @(negedge clk);
    send_byte(8'hF0);
    check("pre_reset_valid", 32'(char_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midreset_valid", 32'(char_valid), 32'h0);
    check("midreset_data", 32'(char_data), 32'h0);
    check("midreset_overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_valid", 32'(char_valid), 32'h0);
    char_ready = 1'b1;
    send_byte(8'h1C);
    check("post_reset_char_valid", 32'(char_valid), 32'h1);
    check("post_reset_char_data", 32'(char_data), 32'h41);
    @(negedge clk);
    check("post_reset_consumed", 32'(char_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
